// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for serial_subtractor.
// SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow flag to the bus.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;
`endif

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB-first, one bit per clock.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the registered signed-overflow output (bus.ovf).
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic             accept;
   logic             last;
   logic [WIDTH-1:0] a_sr, b_sr;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_nxt;
   logic             borrow;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] diff_q;
   logic             bout_q;

   // full-subtractor cell
   logic x, y, c, d, bnxt;
   assign x    = a_sr[0];
   assign y    = b_sr[0];
   assign c    = borrow;
   assign d    = x ^ y ^ c;
   assign bnxt = (~x & y) | (~(x ^ y) & c);

   // result enters at the MSB; the low bit of r_nxt only ever lands in diff
   assign r_nxt = {d, r_sr};
   assign last  = (cnt == CW'(WIDTH - 1));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = SHIFT;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         r_sr   <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= bus.bin;
            cnt    <= '0;
         end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            r_sr   <= r_nxt[WIDTH-1:1];
            borrow <= bnxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
               diff_q <= r_nxt;
               bout_q <= bnxt;
            end
         end
      end
   end

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   // on the last bit x/y are the captured operand MSBs and d is the result MSB
   logic ovf_q;
   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (state == SHIFT && last)
         ovf_q <= (x != y) && (d != x);
   end
   assign bus.ovf = ovf_q;
`endif

   assign bus.busy = (state == SHIFT);
   assign bus.done = (state == DONE);
   assign bus.diff = diff_q;
   assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [W-1:0] prev_diff = '0;

   serial_subtractor_if #(.WIDTH(W)) bif ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // called at a negedge; leaves the bench at the negedge of the done cycle with start=0
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit hold);
      int  n;
      int  r;
      bit  seen;
      logic [W-1:0] ed;
      bif.a = a; bif.b = b; bif.bin = bi; bif.start = 1'b1;
      r    = int'(a) - int'(b) - int'(bi);
      ed   = W'(r & ((1 << W) - 1));
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 3*W) begin
         @(negedge clk);
         n++;
         if (!hold) bif.start = 1'b0;
         bif.a = W'($urandom); bif.b = W'($urandom); bif.bin = 1'($urandom);
         if (bif.done) seen = 1'b1;
         else begin
            chk("busy", 32'(bif.busy), 32'(n <= W));
            if (n == W/2) chk("diff_hold", 32'(bif.diff), 32'(prev_diff));
         end
      end
      bif.start = 1'b0;
      chk("latency", 32'(n), 32'(W + 1));
      chk("done_busy", 32'(bif.busy), 32'd0);
      chk("diff", 32'(bif.diff), 32'(ed));
      chk("bout", 32'(bif.bout), 32'(r < 0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("ovf", 32'(bif.ovf), 32'((a[W-1] != b[W-1]) && (ed[W-1] != a[W-1])));
`endif
      prev_diff = ed;
   endtask

   task automatic idle_chk();
      @(negedge clk);
      chk("idle_busy", 32'(bif.busy), 32'd0);
      chk("idle_done", 32'(bif.done), 32'd0);
   endtask

   initial begin
      bif.start = 1'b0; bif.a = '0; bif.b = '0; bif.bin = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_done", 32'(bif.done), 32'd0);
      chk("rst_diff", 32'(bif.diff), 32'd0);
      chk("rst_bout", 32'(bif.bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      chk("rst_ovf", 32'(bif.ovf), 32'd0);
`endif
      rst = 1'b0;
      idle_chk();

      do_op(8'h5A, 8'h23, 1'b0, 1'b0); idle_chk();
      do_op(8'h00, 8'h01, 1'b0, 1'b0); idle_chk();
      do_op(8'h10, 8'h0F, 1'b1, 1'b0); idle_chk();
      do_op(8'hFF, 8'h00, 1'b1, 1'b0); idle_chk();
      do_op(8'h00, 8'hFF, 1'b1, 1'b0); idle_chk();

      // start held through the whole operation: one result, no restart
      do_op(8'hC4, 8'h3B, 1'b0, 1'b1); idle_chk();

      // back-to-back: start in the DONE cycle
      do_op(8'h77, 8'h11, 1'b0, 1'b0);
      do_op(8'h03, 8'h01, 1'b0, 1'b0); idle_chk();

`ifdef SERIAL_SUBTRACTOR_OVF_EN
      do_op(8'h80, 8'h01, 1'b0, 1'b0); idle_chk();
      do_op(8'h05, 8'h03, 1'b0, 1'b0); idle_chk();
      do_op(8'h7F, 8'hFF, 1'b0, 1'b0); idle_chk();
`endif

      // reset during the 4th SHIFT cycle aborts without a done pulse
      bif.a = 8'h9C; bif.b = 8'h21; bif.bin = 1'b0; bif.start = 1'b1;
      @(negedge clk); bif.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(bif.busy), 32'd0);
      chk("abort_done", 32'(bif.done), 32'd0);
      chk("abort_diff", 32'(bif.diff), 32'd0);
      chk("abort_bout", 32'(bif.bout), 32'd0);
      begin
         bit any_done = 1'b0;
         for (int i = 0; i < 2*W; i++) begin
            @(negedge clk);
            if (bif.done || bif.busy) any_done = 1'b1;
         end
         chk("abort_quiet", 32'(any_done), 32'd0);
      end
      prev_diff = '0;

      for (int i = 0; i < 1000; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 7) == 0));
         if ($urandom_range(0, 1) == 0) idle_chk();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
